// File: rtl/sprite_raster_pkg.sv
// rtl/sprite_raster_pkg.sv - shared geometry constants and FSM encoding for the sprite raster buffer
package sprite_raster_pkg;

  localparam int IMG_W     = 48;
  localparam int IMG_H     = 48;
  localparam int ORIGIN    = 24;
  localparam int ROW_IDX_W = 6;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_SWAP  = 3'd4;

endpackage

// File: rtl/coord_quantizer.sv
// rtl/coord_quantizer.sv - round a signed fixed-point coordinate to a pixel index and bounds-check it
module coord_quantizer
  import sprite_raster_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int FRAC_W  = 2,
  parameter int OFFSET  = 24,
  parameter int LIMIT   = 48
) (
  input  logic signed [COORD_W-1:0]   coord_i,
  output logic        [ROW_IDX_W-1:0] idx_o,
  output logic                        in_range_o
);

  localparam int SUM_W = COORD_W + 1;
  localparam int PIX_W = COORD_W + 2;
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1 << (FRAC_W - 1));

  logic signed [SUM_W-1:0] ext;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] rounded;
  logic signed [PIX_W-1:0] pix;

  // One guard bit keeps the +0.5 from wrapping; the arithmetic shift floors toward -inf.
  assign ext     = {coord_i[COORD_W-1], coord_i};
  assign sum     = ext + HALF;
  assign rounded = sum >>> FRAC_W;
  assign pix     = {rounded[SUM_W-1], rounded} + PIX_W'(OFFSET);

  assign in_range_o = !pix[PIX_W-1] && (pix < PIX_W'(LIMIT));
  assign idx_o      = pix[ROW_IDX_W-1:0];

endmodule

// File: rtl/sprite_raster_buffer.sv
// rtl/sprite_raster_buffer.sv - double-buffered 48x48 bitmap rasteriser for rotated sprite points
module sprite_raster_buffer
  import sprite_raster_pkg::*;
#(
  parameter int IMG_W   = sprite_raster_pkg::IMG_W,
  parameter int IMG_H   = sprite_raster_pkg::IMG_H,
  parameter int COORD_W = 10,
  parameter int FRAC_W  = 2,
  parameter int ORIGIN  = sprite_raster_pkg::ORIGIN
) (
  input  logic                      clk,
  input  logic                      areset_n,
  input  logic                      frame_start,
  input  logic                      frame_end,
  input  logic                      pt_valid,
  input  logic signed [COORD_W-1:0] pt_x,
  input  logic signed [COORD_W-1:0] pt_y,
  output logic                      ready,
  output logic                      busy,
  output logic                      frame_done,
  input  logic [ROW_IDX_W-1:0]      rd_row,
  output logic [IMG_W-1:0]          rd_data,
  output logic [7:0]                drop_count
);

  logic [2:0]           state_q, state_d;
  logic [ROW_IDX_W-1:0] clr_row_q, clr_row_d;
  logic                 drain_cnt_q, drain_cnt_d;

  logic                 s1_valid_q, s1_inb_q;
  logic [ROW_IDX_W-1:0] s1_col_q, s1_row_q;
  logic                 s2_valid_q;
  logic [ROW_IDX_W-1:0] s2_col_q, s2_row_q;

  logic                 front_sel_q;
  logic                 frame_done_q;
  logic [7:0]           drop_q;
  logic [IMG_W-1:0]     rd_data_q;
  logic [IMG_W-1:0]     rd_next;

  // front_sel_q = 0: bm0 is displayed, bm1 is drawn into; swapped on every SWAP
  logic [IMG_W-1:0]     bm0_q [IMG_H];
  logic [IMG_W-1:0]     bm1_q [IMG_H];

  logic [ROW_IDX_W-1:0] q_col, q_row;
  logic                 col_ok, row_ok;
  logic                 accept, abort, start_ok, clr_en;

  coord_quantizer #(
    .COORD_W (COORD_W),
    .FRAC_W  (FRAC_W),
    .OFFSET  (ORIGIN),
    .LIMIT   (IMG_W)
  ) u_quant_x (
    .coord_i    (pt_x),
    .idx_o      (q_col),
    .in_range_o (col_ok)
  );

  coord_quantizer #(
    .COORD_W (COORD_W),
    .FRAC_W  (FRAC_W),
    .OFFSET  (ORIGIN),
    .LIMIT   (IMG_H)
  ) u_quant_y (
    .coord_i    (pt_y),
    .idx_o      (q_row),
    .in_range_o (row_ok)
  );

  assign ready    = (state_q == ST_ACCUM);
  assign busy     = (state_q == ST_CLEAR) || (state_q == ST_DRAIN) || (state_q == ST_SWAP);
  assign accept   = pt_valid && ready;
  assign abort    = frame_start && ready;
  assign start_ok = frame_start && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
  assign clr_en   = (state_q == ST_CLEAR);

  assign frame_done = frame_done_q;
  assign drop_count = drop_q;
  assign rd_data    = rd_data_q;

  // Frame sequencing: clear back rows, accumulate points, drain the pipe, then swap.
  always_comb begin
    state_d     = state_q;
    clr_row_d   = clr_row_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d   = ST_CLEAR;
          clr_row_d = '0;
        end
      end
      ST_CLEAR: begin
        if (frame_start) begin
          clr_row_d = '0;
        end else if (clr_row_q == ROW_IDX_W'(IMG_H - 1)) begin
          state_d = ST_ACCUM;
        end else begin
          clr_row_d = clr_row_q + 1'b1;
        end
      end
      ST_ACCUM: begin
        if (frame_start) begin
          state_d   = ST_CLEAR;
          clr_row_d = '0;
        end else if (frame_end) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Second drain cycle: S1 is empty and S2 retires on this same edge,
        // so the back bitmap is complete when SWAP is entered.
        if (drain_cnt_q && !s1_valid_q) begin
          state_d = ST_SWAP;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      ST_SWAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, clear counter, buffer select and done pulse registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= ST_IDLE;
      clr_row_q    <= '0;
      drain_cnt_q  <= 1'b0;
      front_sel_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_row_q    <= clr_row_d;
      drain_cnt_q  <= drain_cnt_d;
      frame_done_q <= (state_q == ST_SWAP);
      if (state_q == ST_SWAP) begin
        front_sel_q <= ~front_sel_q;
      end
    end
  end

  // Two-stage point pipeline; an aborting frame_start squashes anything in flight.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      s1_valid_q <= 1'b0;
      s1_inb_q   <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_col_q   <= '0;
      s2_row_q   <= '0;
    end else begin
      s1_valid_q <= accept && !abort;
      if (accept) begin
        s1_inb_q <= col_ok && row_ok;
        s1_col_q <= q_col;
        s1_row_q <= q_row;
      end
      s2_valid_q <= s1_valid_q && s1_inb_q && !abort;
      s2_col_q   <= s1_col_q;
      s2_row_q   <= s1_row_q;
    end
  end

  // Out-of-bounds counter, cleared by each frame start that is acted on.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      drop_q <= '0;
    end else if (start_ok) begin
      drop_q <= '0;
    end else if (accept && !(col_ok && row_ok) && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  // bm0 is only touched while it is the back buffer.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int r = 0; r < IMG_H; r++) bm0_q[r] <= '0;
    end else if (front_sel_q) begin
      if (clr_en) bm0_q[clr_row_q] <= '0;
      if (s2_valid_q) bm0_q[s2_row_q][s2_col_q] <= 1'b1;
    end
  end

  // bm1 is only touched while it is the back buffer.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int r = 0; r < IMG_H; r++) bm1_q[r] <= '0;
    end else if (!front_sel_q) begin
      if (clr_en) bm1_q[clr_row_q] <= '0;
      if (s2_valid_q) bm1_q[s2_row_q][s2_col_q] <= 1'b1;
    end
  end

  // Front row select; rows past the bitmap read as zero.
  always_comb begin
    rd_next = '0;
    if ({1'b0, rd_row} < (ROW_IDX_W + 1)'(IMG_H)) begin
      rd_next = front_sel_q ? bm1_q[rd_row] : bm0_q[rd_row];
    end
  end

  // Registered readout, one cycle behind rd_row.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_next;
    end
  end

endmodule

// File: tb/tb_sprite_raster_buffer.sv
// tb/tb_sprite_raster_buffer.sv - directed scoreboard bench for sprite_raster_buffer
module tb_sprite_raster_buffer;

  logic              clk = 1'b0;
  logic              areset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              frame_end = 1'b0;
  logic              pt_valid = 1'b0;
  logic signed [9:0] pt_x = '0;
  logic signed [9:0] pt_y = '0;
  logic              ready;
  logic              busy;
  logic              frame_done;
  logic [5:0]        rd_row = '0;
  logic [47:0]       rd_data;
  logic [7:0]        drop_count;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int drops_m = 0;
  int d0;
  logic [47:0] exp_q [$];
  logic [47:0] front_m [48];
  logic [47:0] back_m [48];

  always #5 clk = ~clk;

  sprite_raster_buffer dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pt_valid    (pt_valid),
    .pt_x        (pt_x),
    .pt_y        (pt_y),
    .ready       (ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .drop_count  (drop_count)
  );

  always @(posedge clk) begin
    #2;
    if (frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int quant(input int raw);
    return $rtoi($floor(real'(raw) / 4.0 + 0.5)) + 24;
  endfunction

  task automatic model_pt(input int x, input int y);
    int cx, cy;
    cx = quant(x);
    cy = quant(y);
    if (cx >= 0 && cx < 48 && cy >= 0 && cy < 48) back_m[cy][cx] = 1'b1;
    else if (drops_m < 255) drops_m++;
  endtask

  task automatic rd(input int r, input string tag);
    logic [47:0] e;
    logic [47:0] got;
    e = '0;
    if (r < 48) e = front_m[r];
    rd_row = 6'(r);
    exp_q.push_back(e);
    tick();
    got = exp_q.pop_front();
    chk(tag, 64'(rd_data), 64'(got));
  endtask

  task automatic pt(input int x, input int y);
    pt_valid = 1'b1;
    pt_x = 10'(x);
    pt_y = 10'(y);
    model_pt(x, y);
    tick();
    pt_valid = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    int n;
    int dstart;
    dstart = done_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int r = 0; r < 48; r++) back_m[r] = '0;
    drops_m = 0;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_clear_len"}, 64'(n), 64'(48));
    chk({tag, "_no_done"}, 64'(done_cnt), 64'(dstart));
    chk({tag, "_drop_clr"}, 64'(drop_count), 64'(drops_m));
  endtask

  task automatic end_frame(input string tag, input bit with_pt, input int x, input int y);
    int n;
    frame_end = 1'b1;
    if (with_pt) begin
      pt_valid = 1'b1;
      pt_x = 10'(x);
      pt_y = 10'(y);
      model_pt(x, y);
    end
    tick();
    frame_end = 1'b0;
    pt_valid = 1'b0;
    chk({tag, "_drain_busy"}, 64'(busy), 64'(1));
    n = 1;
    while (frame_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_done_lat"}, 64'(n), 64'(4));
    for (int r = 0; r < 48; r++) front_m[r] = back_m[r];
    tick();
    chk({tag, "_done_pulse"}, 64'(frame_done), 64'(0));
    chk({tag, "_idle"}, 64'({ready, busy}), 64'(0));
  endtask

  initial begin
    for (int r = 0; r < 48; r++) begin
      front_m[r] = '0;
      back_m[r] = '0;
    end

    // Reset state
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_drop", 64'(drop_count), 64'(0));
    chk("rst_rdata", 64'(rd_data), 64'(0));
    areset_n = 1'b1;
    tick();
    for (int r = 0; r < 48; r++) rd(r, "reset_row");
    rd(50, "row_oob");

    // First frame: point at the origin presented with frame_end
    start_frame("f1");
    end_frame("f1", 1'b1, 0, 0);
    rd(24, "f1_row24");
    chk("f1_row24_const", 64'(rd_data), 64'(48'h1) << 24);
    rd(23, "f1_row23");

    // Rounding and bounds
    start_frame("f2");
    pt(-88, 0);
    pt(93, 0);
    pt(95, 0);
    chk("f2_drop", 64'(drop_count), 64'(drops_m));
    chk("f2_drop_const", 64'(drop_count), 64'(1));
    end_frame("f2", 1'b0, 0, 0);
    rd(24, "f2_row24");
    chk("f2_row24_const", 64'(rd_data), (64'(48'h1) << 2) | (64'(48'h1) << 47));
    rd(25, "f2_row25");

    // Points while not ready are ignored and not counted
    pt_valid = 1'b1;
    pt_x = 10'(400);
    pt_y = 10'(0);
    repeat (5) tick();
    pt_valid = 1'b0;
    chk("idle_pt_drop", 64'(drop_count), 64'(1));
    rd(24, "idle_pt_row24");

    // Double buffering: frame A then frame B
    start_frame("fa");
    pt(0, 0);
    end_frame("fa", 1'b0, 0, 0);
    rd(24, "fa_row24");
    start_frame("fb");
    pt(24, 24);
    rd(24, "fb_mid_row24");
    chk("fb_mid_const", 64'(rd_data), 64'(48'h1) << 24);
    end_frame("fb", 1'b0, 0, 0);
    rd(24, "fb_row24");
    chk("fb_row24_const", 64'(rd_data), 64'(0));
    rd(30, "fb_row30");
    chk("fb_row30_const", 64'(rd_data), 64'(48'h1) << 30);

    // Abort: second frame_start in ACCUM
    start_frame("fc");
    pt(-40, 0);
    d0 = done_cnt;
    start_frame("abort");
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    rd(30, "abort_front30");
    rd(24, "abort_front24");
    end_frame("post_abort", 1'b0, 0, 0);
    rd(24, "post_abort_row24");
    rd(30, "post_abort_row30");

    // Async reset during DRAIN
    start_frame("fr");
    pt(0, 0);
    pt(400, 0);
    chk("fr_drop", 64'(drop_count), 64'(drops_m));
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("fr_drain_busy", 64'(busy), 64'(1));
    areset_n = 1'b0;
    d0 = done_cnt;
    tick();
    chk("fr_rst_ready", 64'(ready), 64'(0));
    chk("fr_rst_busy", 64'(busy), 64'(0));
    chk("fr_rst_drop", 64'(drop_count), 64'(0));
    chk("fr_rst_rdata", 64'(rd_data), 64'(0));
    tick();
    areset_n = 1'b1;
    for (int r = 0; r < 48; r++) begin
      front_m[r] = '0;
      back_m[r] = '0;
    end
    drops_m = 0;
    repeat (8) tick();
    chk("fr_no_done", 64'(done_cnt), 64'(d0));
    chk("fr_idle", 64'({ready, busy}), 64'(0));
    rd(24, "fr_row24");
    rd(30, "fr_row30");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
